// File: rtl/button_debounce.sv
// button_debounce: raw button synchronizer and debounce FSM, one per button.
// Define BUTTON_DEBOUNCE_INVERT_EN for active-low raw inputs.
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic pressed,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  // bit 1 = pressed, bit 0 = busy, so outputs come straight off flops
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    RISE_WAIT   = 2'b01,
    STABLE_HIGH = 2'b10,
    FALL_WAIT   = 2'b11
  } state_t;

  logic                   raw_in;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [CW-1:0]          cnt_inc;
  state_t                 state_q;
  state_t                 state_d;

`ifdef BUTTON_DEBOUNCE_INVERT_EN
  assign raw_in = ~raw;
`else
  assign raw_in = raw;
`endif

  // metastability chain; only the last stage is used
  always_ff @(posedge Clock) begin
    if (Reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  assign sync    = sync_q[SYNC_STAGES-1];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // state and counter registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state: time how long sync disagrees with the debounced level
  always_comb begin
    state_d = STABLE_LOW;
    cnt_d   = '0;
    case (state_q)
      STABLE_LOW: begin
        if (sync) begin
          state_d = RISE_WAIT;
          cnt_d   = CW'(1);
        end
      end
      RISE_WAIT: begin
        if (!sync) begin
          state_d = STABLE_LOW;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HIGH;
        end else begin
          state_d = RISE_WAIT;
          cnt_d   = cnt_inc;
        end
      end
      STABLE_HIGH: begin
        if (!sync) begin
          state_d = FALL_WAIT;
          cnt_d   = CW'(1);
        end else begin
          state_d = STABLE_HIGH;
        end
      end
      FALL_WAIT: begin
        if (sync) begin
          state_d = STABLE_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LOW;
        end else begin
          state_d = FALL_WAIT;
          cnt_d   = cnt_inc;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign pressed = state_q[1];
  assign busy    = state_q[0];

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: random and directed stimulus against a run-length
// model of the debouncer, plus literal latency checks.
module tb_button_debounce;

  localparam int S = 2;
  localparam int D = 4;

`ifdef BUTTON_DEBOUNCE_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic Clock;
  logic Reset;
  logic raw;
  logic pressed;
  logic busy;

  int checks;
  int errors;

  bit hist[$];
  bit mp;
  int run;
  bit mb;

  button_debounce #(
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .raw(raw),
    .pressed(pressed),
    .busy(busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic lit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock: drive, advance model, compare outputs to model
  task automatic step(input bit lvl, input bit rst);
    bit s;
    raw   = lvl ^ INV;
    Reset = rst;
    @(posedge Clock);
    if (rst) begin
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back(1'b0);
      mp  = 1'b0;
      run = 0;
    end else begin
      s = hist.pop_front();
      hist.push_back(lvl);
      if (s != mp) run++;
      else         run = 0;
      if (run == D + 1) begin
        mp  = s;
        run = 0;
      end
    end
    mb = (run > 0);
    #1;
    lit("model_pressed", pressed, mp);
    lit("model_busy", busy, mb);
  endtask

  initial begin
    bit saw_busy;
    bit pat[6];
    checks = 0;
    errors = 0;
    mp     = 1'b0;
    run    = 0;
    for (int i = 0; i < S; i++) hist.push_back(1'b0);
    raw   = INV;
    Reset = 1'b1;

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    lit("reset_pressed", pressed, 1'b0);
    lit("reset_busy", busy, 1'b0);

    // clean press
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      step(1'b1, 1'b0);
      lit("press_pressed", pressed, logic'(e >= 7));
      lit("press_busy", busy, logic'(e >= 3 && e <= 6));
    end

    // release with a 2-cycle blip: final fall 7 edges after edge 6
    for (int e = 1; e <= 14; e++) begin
      step((e == 4 || e == 5), 1'b0);
      lit("blip_release", pressed, logic'(e < 12));
    end

    // glitch of 3 cycles
    saw_busy = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step(e <= 3, 1'b0);
      lit("glitch_pressed", pressed, 1'b0);
      saw_busy |= busy;
    end
    lit("glitch_saw_busy", saw_busy, 1'b1);
    lit("glitch_idle", busy, 1'b0);

    // bounce then settle
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step(pat[i], 1'b0);
      lit("bounce_early", pressed, 1'b0);
    end
    for (int e = 1; e <= 10; e++) begin
      step(1'b1, 1'b0);
      lit("bounce_settle", pressed, logic'(e >= 7));
    end

    // plain release
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 1'b0);
      lit("release", pressed, logic'(e < 7));
    end

    // reset mid-count (counter reaches 3 on the 5th edge)
    for (int e = 1; e <= 5; e++) step(1'b1, 1'b0);
    lit("midcnt_busy", busy, 1'b1);
    step(1'b1, 1'b1);
    lit("midrst_pressed", pressed, 1'b0);
    lit("midrst_busy", busy, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      step(1'b1, 1'b0);
      lit("after_rst", pressed, logic'(e >= 7));
    end

    // random runs with occasional reset
    for (int n = 0; n < 250; n++) begin
      int len;
      bit v;
      bit rs;
      len = $urandom_range(1, 12);
      v   = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 40) == 0);
      for (int k = 0; k < len; k++) step(v, rs && k == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-conditioning stage directly upstream of the press one-pulse FSM.
- Takes a raw, asynchronous, bouncing push-button/switch signal and synchronizes it into the Clock domain.
- Filters bounce and glitches, then drives a clean, glitch-free level on `pressed`, which feeds the one-pulse stage's `pressed` input.
- One instance per button.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the metastability synchronizer chain; legal range 2..4.
- DEBOUNCE_CYCLES, 4, number of consecutive cycles the synchronized value must differ from `pressed` before `pressed` changes; legal range ≥1. The board build uses 50000 (1 ms at 50 MHz); benches use 4.

Ports:
- Clock   input  1  system clock; all state updates on its rising edge.
- Reset   input  1  synchronous, active-high reset.
- raw     input  1  asynchronous button level; 1 = pressed unless the optional inversion is compiled in.
- pressed output 1  debounced, synchronized level; feeds the one-pulse stage.
- busy    output 1  1 while a candidate transition is being timed (states RISE_WAIT, FALL_WAIT).

Behaviour:
- Reset: one clock; reset is synchronous and active-high. At a rising Clock edge with Reset=1:
  - all synchronizer flops ← 0
  - counter ← 0
  - state ← STABLE_LOW
  - pressed=0, busy=0
- Reset has priority over every other event, including mid-count; any partial count is discarded.
- Synchronizer: shift register of SYNC_STAGES flops, with `raw` entering stage 0. `sync` is the last stage. Only `sync` is used by the FSM; no logic reads earlier stages.
- Counter: width $clog2(DEBOUNCE_CYCLES+1); saturates, never wraps.
- State machine, evaluated every edge when Reset=0:
  - STABLE_LOW (pressed=0, busy=0): if sync=1, go to RISE_WAIT with counter←1; else stay, counter←0.
  - RISE_WAIT (pressed=0, busy=1):
    - sync=0: back to STABLE_LOW, counter←0 (glitch rejected).
    - sync=1 and counter==DEBOUNCE_CYCLES: go to STABLE_HIGH, counter←0.
    - otherwise: counter←counter+1.
  - STABLE_HIGH (pressed=1, busy=0): if sync=0, go to FALL_WAIT with counter←1; else stay.
  - FALL_WAIT (pressed=1, busy=1):
    - sync=1: back to STABLE_HIGH, counter←0.
    - sync=0 and counter==DEBOUNCE_CYCLES: go to STABLE_LOW, counter←0.
    - otherwise: counter←counter+1.
  - Unreachable encodings recover to STABLE_LOW on the next edge.
- Outputs are registered Moore outputs decoded from state; no combinational path from `raw`.
- Latency: `raw` steady from edge 0 → `sync` reflects it after SYNC_STAGES edges → `pressed` changes after a further DEBOUNCE_CYCLES+1 edges.
  - Total: SYNC_STAGES+DEBOUNCE_CYCLES+1 edges (7 with defaults), identical for rise and fall.
- Glitch rejection: any `sync` pulse of ≤DEBOUNCE_CYCLES cycles never changes `pressed`.
- Each bounce restarts the count from 1.
- `pressed` changes at most once per DEBOUNCE_CYCLES+1 cycles.
- DEBOUNCE_CYCLES=1: a `sync` change must persist 2 edges.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_INVERT_EN.
- Defined: `raw` is inverted before synchronizer stage 0, so raw=0 means pressed (DE1-SoC KEY pushbuttons are active-low). Reset still clears the flops to 0, i.e. "not pressed"; pressed=0 after reset regardless of the `raw` level.
- Undefined: no inversion; raw=1 means pressed.
- All other timing is identical.

Test Plan (defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro undefined unless stated):
- Clean press:
  - Stimulus: Reset 2 cycles, raw=0 for 5 cycles, then raw=1 steady.
  - Required: pressed=0 for the first 6 edges after raw rises; pressed=1 from the 7th edge onward.
  - Required: busy=1 on edges 3–6, busy=0 otherwise.
- Glitch:
  - Stimulus: raw=1 for exactly 3 cycles, then 0.
  - Required: pressed stays 0 throughout; busy pulses, then returns to 0; state returns to STABLE_LOW.
- Bounce then settle:
  - Stimulus: raw pattern 1,0,1,1,0,1 (one cycle each), then 1 steady.
  - Required: pressed rises exactly 7 edges after the final 0→1 transition and never toggles before that.
- Release:
  - Stimulus: from pressed=1, raw→0 steady.
  - Required: pressed falls on the 7th edge.
  - Stimulus: a 2-cycle raw=1 blip during the count.
  - Required: the count restarts; the fall is delayed accordingly.
- Reset mid-count:
  - Stimulus: raw=1 held; assert Reset for 1 cycle when busy=1 with counter=3.
  - Required: next edge shows pressed=0, busy=0.
  - Required: pressed rises 7 edges after Reset deasserts (synchronizer refilled).
- Inverted build (BUTTON_DEBOUNCE_INVERT_EN defined):
  - Stimulus: raw=1 idle, raw=0 steady.
  - Required: pressed=0 while idle and immediately after reset; pressed=1 on the 7th edge after raw falls.
